modulo_conversor_bcd_rolhas: RTL and testbench

Parametrised sequential binary-to-BCD converter for the stopper-count path. It generalises the combinational units-digit encoder: it produces all decimal digits, not only units, for any input width. Conversion uses the iterative shift-add-3 (double-dabble) method with a start/busy/done handshake. An optional range check saturates or flags counts above a maximum stock value. Its output drives the display/decoder stage.

---
 rtl/modulo_conversor_bcd_rolhas.sv | 128 ++++++++++++
 tb/tb_modulo_conversor_bcd_rolhas.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/modulo_conversor_bcd_rolhas.sv
// Sequential binary-to-BCD converter (shift-add-3) for the stopper count path,
// with start/busy/done handshake and optional saturation above MAX_VAL.
module modulo_conversor_bcd_rolhas #(
  parameter int WIDTH   = 7,
  parameter int DIGITS  = 3,
  parameter int MAX_VAL = 99,
  parameter int SAT     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      int_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   s,
  output logic                  ovf
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam int BW = 4 * DIGITS;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [32:0]   MAX_U    = 33'(MAX_VAL);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    sr_q, sr_d;
  logic [BW-1:0]       acc_q, acc_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                ovf_next_q, ovf_next_d;
  logic [BW-1:0]       s_q, s_d;
  logic                ovf_q, ovf_d;

  logic                over_s;
  logic [BW+WIDTH-1:0] shifted_s;

  // Digits are corrected independently: a digit never carries into its neighbour.
  function automatic logic [BW-1:0] add3(input logic [BW-1:0] a);
    logic [BW-1:0] r;
    r = a;
    for (int k = 0; k < DIGITS; k++) begin
      if (a[4*k +: 4] >= 4'd5) begin
        r[4*k +: 4] = a[4*k +: 4] + 4'd3;
      end else begin
        r[4*k +: 4] = a[4*k +: 4];
      end
    end
    return r;
  endfunction

  // Next-state, datapath and result-capture logic
  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    ovf_next_d = ovf_next_q;
    s_d        = s_q;
    ovf_d      = ovf_q;
    over_s     = ({{(33-WIDTH){1'b0}}, int_in} > MAX_U);
    shifted_s  = {add3(acc_q), sr_q} << 1;

    case (state_q)
      // DONE accepts a new start so back-to-back conversions take WIDTH+1 cycles
      IDLE, DONE: begin
        if (start) begin
          if ((SAT != 0) && over_s) begin
            sr_d = MAX_U[WIDTH-1:0];
          end else begin
            sr_d = int_in;
          end
          ovf_next_d = over_s;
          acc_d      = '0;
          cnt_d      = '0;
          state_d    = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        acc_d = shifted_s[BW+WIDTH-1:WIDTH];
        sr_d  = shifted_s[WIDTH-1:0];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          s_d     = shifted_s[BW+WIDTH-1:WIDTH];
          ovf_d   = ovf_next_q;
        end else begin
          state_d = SHIFT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_next_q <= 1'b0;
      s_q        <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      ovf_next_q <= ovf_next_d;
      s_q        <= s_d;
      ovf_q      <= ovf_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign s    = s_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_modulo_conversor_bcd_rolhas.sv
// Directed self-checking bench: default, SAT=0 and 10-bit instances of the converter.
module tb_modulo_conversor_bcd_rolhas;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start_v = 1'b0;
  logic [9:0] int_v = '0;
  logic [1:0] sel = 2'd0;
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic start_a, start_b, start_c;
  logic busy_a, busy_b, busy_c, done_a, done_b, done_c, ovf_a, ovf_b, ovf_c;
  logic [11:0] s_a, s_b;
  logic [15:0] s_c;
  logic busy_m, done_m, ovf_m;
  logic [15:0] s_m;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign start_a = start_v && (sel == 2'd0);
  assign start_b = start_v && (sel == 2'd1);
  assign start_c = start_v && (sel == 2'd2);
  assign busy_m = (sel == 2'd0) ? busy_a : (sel == 2'd1) ? busy_b : busy_c;
  assign done_m = (sel == 2'd0) ? done_a : (sel == 2'd1) ? done_b : done_c;
  assign ovf_m  = (sel == 2'd0) ? ovf_a  : (sel == 2'd1) ? ovf_b  : ovf_c;
  assign s_m    = (sel == 2'd0) ? {4'h0, s_a} : (sel == 2'd1) ? {4'h0, s_b} : s_c;

  modulo_conversor_bcd_rolhas u_dut_a (
    .clk(clk), .reset(reset), .start(start_a), .int_in(int_v[6:0]),
    .busy(busy_a), .done(done_a), .s(s_a), .ovf(ovf_a));

  modulo_conversor_bcd_rolhas #(.WIDTH(7), .DIGITS(3), .MAX_VAL(99), .SAT(0)) u_dut_b (
    .clk(clk), .reset(reset), .start(start_b), .int_in(int_v[6:0]),
    .busy(busy_b), .done(done_b), .s(s_b), .ovf(ovf_b));

  modulo_conversor_bcd_rolhas #(.WIDTH(10), .DIGITS(4), .MAX_VAL(1023), .SAT(1)) u_dut_c (
    .clk(clk), .reset(reset), .start(start_c), .int_in(int_v),
    .busy(busy_c), .done(done_c), .s(s_c), .ovf(ovf_c));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One full conversion on the selected instance, checking latency and pulse width.
  task automatic run(input logic [1:0] which, input logic [9:0] v, input logic [15:0] es,
                     input logic eo, input int lat, input string tag);
    int n;
    @(negedge clk);
    sel = which;
    int_v = v;
    start_v = 1'b1;
    @(posedge clk); #1;
    check({tag, "_busy"}, 32'(busy_m), 32'd1);
    start_v = 1'b0;
    n = 0;
    while (!done_m && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_lat"}, n, lat);
    check({tag, "_s"}, 32'(s_m), 32'(es));
    check({tag, "_ovf"}, 32'(ovf_m), 32'(eo));
    @(posedge clk); #1;
    check({tag, "_done1"}, 32'(done_m), 32'd0);
    check({tag, "_idle"}, 32'(busy_m), 32'd0);
  endtask

  initial begin
    int t0, t1, t2, n, seen;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_s", 32'(s_a), 32'd0);
    check("rst_ovf", 32'(ovf_a), 32'd0);

    run(2'd0, 10'd57,  16'h0057, 1'b0, 7, "d57");
    run(2'd0, 10'd0,   16'h0000, 1'b0, 7, "d0");
    run(2'd0, 10'd99,  16'h0099, 1'b0, 7, "d99");
    run(2'd0, 10'd100, 16'h0099, 1'b1, 7, "d100sat");
    run(2'd1, 10'd127, 16'h0127, 1'b1, 7, "ns127");
    run(2'd1, 10'd9,   16'h0009, 1'b0, 7, "ns9");
    run(2'd2, 10'd1023, 16'h1023, 1'b0, 10, "w1023");
    run(2'd2, 10'd512,  16'h0512, 1'b0, 10, "w512");

    // start held high: completions every WIDTH+1 cycles
    @(negedge clk);
    sel = 2'd0; int_v = 10'd42; start_v = 1'b1;
    t0 = -1; t1 = -1; t2 = -1; n = 0;
    while (t2 < 0 && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (done_m) begin
        if (t0 < 0) t0 = cyc;
        else if (t1 < 0) t1 = cyc;
        else t2 = cyc;
      end
    end
    check("hold_gap1", t1 - t0, 8);
    check("hold_gap2", t2 - t1, 8);
    check("hold_s", 32'(s_m), 32'h042);
    @(negedge clk);
    start_v = 1'b0;
    n = 0;
    while (busy_m && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("hold_drain", 32'(busy_m), 32'd0);

    // int change and start pulse during SHIFT are ignored
    run(2'd0, 10'd0, 16'h0000, 1'b0, 7, "pre");
    @(negedge clk);
    int_v = 10'd42; start_v = 1'b1;
    @(negedge clk);
    start_v = 1'b0; int_v = 10'd99;
    @(negedge clk);
    start_v = 1'b1; int_v = 10'd7;
    @(negedge clk);
    start_v = 1'b0;
    n = 0;
    while (!done_m && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("mid_s", 32'(s_m), 32'h042);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_noqueue", 32'(busy_m), 32'd0);

    // reset at E0+3 aborts the conversion with no done
    @(negedge clk);
    int_v = 10'd88; start_v = 1'b1;
    @(posedge clk); #1;
    start_v = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done_m) seen++;
    end
    check("abort_nodone", seen, 0);
    check("abort_s", 32'(s_m), 32'd0);
    check("abort_ovf", 32'(ovf_m), 32'd0);
    check("abort_busy", 32'(busy_m), 32'd0);
    run(2'd0, 10'd15, 16'h0015, 1'b0, 7, "post15");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
